// File: rtl/keypad_pkg.sv
// Shared keypad geometry, scanner state encoding and row-priority helper.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  // Index of the lowest-numbered active-low row; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
    lowest_low = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction
endpackage

// File: rtl/keypad_prescaler.sv
// Scan-rate divider: free-running 0..SCAN_DIV-1 counter, tick high on the last count.
// Tick is combinational from the count register; no backpressure.
module keypad_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int            PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + PW'(1);
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, debounce, one-deep key buffer on valid/ready.
// key_valid rises the clk after the final debounce tick; a press arriving while full sets overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] rows_in,
  output logic [NUM_COLS-1:0] cols_out,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  logic                tick;
  logic [NUM_ROWS-1:0] sync1, rows_s;
  logic [1:0]          state, state_nxt;
  logic [1:0]          col_idx, col_nxt;
  logic [1:0]          cand_row, cand_nxt, acc_row;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic                accept;
  logic                cand_low;

  keypad_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      rows_s <= '1;
    end else begin
      sync1  <= rows_in;
      rows_s <= sync1;
    end
  end

  assign cand_low = ~rows_s[cand_row];
  assign cnt_inc  = cnt + CNT_W'(1);

  // Column stays frozen from first low sample until release is debounced.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    cand_nxt  = cand_row;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    acc_row   = cand_row;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rows_s != '1) begin
            cand_nxt = lowest_low(rows_s);
            acc_row  = cand_nxt;
            if (DEBOUNCE_CNT == 1) begin
              state_nxt = ST_PRESSED;
              cnt_nxt   = '0;
              accept    = 1'b1;
            end else begin
              state_nxt = ST_DEBOUNCE;
              cnt_nxt   = CNT_W'(1);
            end
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (cand_low) begin
            if (cnt_inc == CNT_DONE) begin
              state_nxt = ST_PRESSED;
              cnt_nxt   = '0;
              accept    = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = ST_SCAN;
            cnt_nxt   = '0;
            col_nxt   = col_idx + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (!cand_low) begin
            if (cnt_inc == CNT_DONE) begin
              state_nxt = ST_SCAN;
              cnt_nxt   = '0;
              col_nxt   = col_idx + 2'd1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_SCAN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SCAN;
      col_idx  <= 2'd0;
      cand_row <= 2'd0;
      cnt      <= '0;
      cols_out <= 4'b1110;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_nxt;
      cand_row <= cand_nxt;
      cnt      <= cnt_nxt;
      cols_out <= ~(4'b0001 << col_nxt);
    end
  end

  // A simultaneous handshake frees the slot for the newly accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      if (!key_valid || key_ready) begin
        key_code  <= {acc_row, col_idx};
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

  assign key_held = (state == ST_PRESSED);
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad driving rows from cols_out.
module tb_keypad_scanner;
  logic       clk;
  logic       rst_n;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  logic       key_down;
  logic [1:0] key_row;
  logic [1:0] key_col;

  int vectors     = 0;
  int miscompares = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows_in   (rows_in),
    .cols_out  (cols_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Pressed switch connects its row to its column only while that column is driven low.
  assign rows_in = (key_down && !cols_out[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input logic v, input string tag);
    int n = 0;
    while (key_valid !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, key_valid}, {7'd0, v});
  endtask

  task automatic wait_held(input logic v, input string tag);
    int n = 0;
    while (key_held !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, key_held}, {7'd0, v});
  endtask

  task automatic wait_cols(input logic [3:0] c, input string tag);
    int n = 0;
    while (cols_out !== c && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {4'd0, cols_out}, {4'd0, c});
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_row  = r;
    key_col  = c;
    key_down = 1'b1;
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_ready = 1'b0;
    key_down  = 1'b0;
    key_row   = 2'd0;
    key_col   = 2'd0;

    // 1. Reset state and idle column walk.
    repeat (3) @(negedge clk);
    chk("rst_cols",    {4'd0, cols_out}, 8'h0e);
    chk("rst_valid",   {7'd0, key_valid}, 8'h00);
    chk("rst_held",    {7'd0, key_held}, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    chk("rst_code",    {4'd0, key_code}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("scan_c0", {4'd0, cols_out}, 8'h0e);
    @(negedge clk);
    chk("scan_c1", {4'd0, cols_out}, 8'h0d);
    repeat (3) @(negedge clk);
    chk("scan_c1_hold", {4'd0, cols_out}, 8'h0d);
    @(negedge clk);
    chk("scan_c2", {4'd0, cols_out}, 8'h0b);
    repeat (4) @(negedge clk);
    chk("scan_c3", {4'd0, cols_out}, 8'h07);
    repeat (4) @(negedge clk);
    chk("scan_wrap", {4'd0, cols_out}, 8'h0e);

    // 2. Key 9 (row2, col1) accepted, then released.
    press(2'd2, 2'd1);
    wait_valid(1'b1, "k9_valid");
    chk("k9_code", {4'd0, key_code}, 8'h09);
    chk("k9_held", {7'd0, key_held}, 8'h01);
    chk("k9_col_frozen", {4'd0, cols_out}, 8'h0d);
    key_down = 1'b0;
    wait_held(1'b0, "k9_release");
    chk("k9_resume_c2", {4'd0, cols_out}, 8'h0b);
    chk("k9_still_valid", {7'd0, key_valid}, 8'h01);
    pulse_ready();
    chk("k9_taken", {7'd0, key_valid}, 8'h00);
    chk("k9_code_hold", {4'd0, key_code}, 8'h09);

    // 3. Two-tick bounce on key 3 is rejected.
    wait_cols(4'b1110, "bounce_sync_c0");
    wait_cols(4'b0111, "bounce_sync_c3");
    press(2'd0, 2'd3);
    repeat (8) @(negedge clk);
    chk("bounce_col_frozen", {4'd0, cols_out}, 8'h07);
    key_down = 1'b0;
    repeat (4) @(negedge clk);
    chk("bounce_resume_c0", {4'd0, cols_out}, 8'h0e);
    chk("bounce_no_valid", {7'd0, key_valid}, 8'h00);
    chk("bounce_no_held", {7'd0, key_held}, 8'h00);

    // 4. Second key while first is pending -> dropped, overrun.
    chk("ovr_clear", {7'd0, overrun}, 8'h00);
    press(2'd2, 2'd1);
    wait_valid(1'b1, "ovr_k9_valid");
    key_down = 1'b0;
    wait_held(1'b0, "ovr_k9_release");
    press(2'd1, 2'd0);
    wait_held(1'b1, "ovr_k4_held");
    chk("ovr_code_kept", {4'd0, key_code}, 8'h09);
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    chk("ovr_valid", {7'd0, key_valid}, 8'h01);
    key_down = 1'b0;
    wait_held(1'b0, "ovr_k4_release");
    pulse_ready();
    chk("ovr_drained", {7'd0, key_valid}, 8'h00);

    // 5. Handshake on the accept cycle of key 6 swaps the buffer.
    press(2'd2, 2'd1);
    wait_valid(1'b1, "swap_k9_valid");
    key_down = 1'b0;
    wait_held(1'b0, "swap_k9_release");
    press(2'd1, 2'd2);
    repeat (11) @(negedge clk);
    chk("swap_pre_valid", {7'd0, key_valid}, 8'h01);
    chk("swap_pre_code", {4'd0, key_code}, 8'h09);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("swap_code6", {4'd0, key_code}, 8'h06);
    chk("swap_valid", {7'd0, key_valid}, 8'h01);
    chk("swap_held", {7'd0, key_held}, 8'h01);
    key_down = 1'b0;
    wait_held(1'b0, "swap_k6_release");
    pulse_ready();
    chk("swap_drained", {7'd0, key_valid}, 8'h00);

    // 6. Asynchronous reset while debouncing key 6 with key 9 pending.
    press(2'd2, 2'd1);
    wait_valid(1'b1, "ar_k9_valid");
    key_down = 1'b0;
    wait_held(1'b0, "ar_k9_release");
    press(2'd1, 2'd2);
    repeat (6) @(negedge clk);
    chk("ar_pre_valid", {7'd0, key_valid}, 8'h01);
    chk("ar_pre_overrun", {7'd0, overrun}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cols", {4'd0, cols_out}, 8'h0e);
    chk("ar_code", {4'd0, key_code}, 8'h00);
    chk("ar_valid", {7'd0, key_valid}, 8'h00);
    chk("ar_held", {7'd0, key_held}, 8'h00);
    chk("ar_overrun", {7'd0, overrun}, 8'h00);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_restart_c0", {4'd0, cols_out}, 8'h0e);
    @(negedge clk);
    chk("ar_restart_c1", {4'd0, cols_out}, 8'h0d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
